// File: rtl/dmem_arbiter.sv
// Purpose: two-requester arbiter for the data-memory port; the pipeline has priority, the aux port gets a forced slot.
// Latency: grant and port mux are combinational; aux read data is returned one cycle after the grant.
// Backpressure: aux holds its request until it sees aux_gnt; after MAX_WAIT denials the CPU stalls for one cycle.
module dmem_arbiter #(
  parameter int DATA_W     = 32,
  parameter int DM_ADDRESS = 9,
  parameter int MAX_WAIT   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_rd,
  input  logic                  cpu_wr,
  input  logic [DM_ADDRESS-1:0] cpu_addr,
  input  logic [DATA_W-1:0]     cpu_wdata,
  input  logic [2:0]            cpu_funct3,
  output logic [DATA_W-1:0]     cpu_rdata,
  output logic                  cpu_stall,
  input  logic                  aux_req,
  input  logic                  aux_we,
  input  logic [DM_ADDRESS-1:0] aux_addr,
  input  logic [DATA_W-1:0]     aux_wdata,
  input  logic [2:0]            aux_funct3,
  output logic                  aux_gnt,
  output logic                  aux_rvalid,
  output logic [DATA_W-1:0]     aux_rdata,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [2:0]            mem_funct3,
  input  logic [DATA_W-1:0]     mem_rdata
);

  typedef enum logic {PRI_CPU = 1'b0, FORCE = 1'b1} state_t;

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  state_t     state, state_nxt;
  logic [3:0] wait_cnt, wait_cnt_nxt;
  logic       cpu_busy;
  logic       cpu_own;

  assign cpu_busy  = cpu_rd | cpu_wr;
  assign cpu_rdata = mem_rdata;

  // State register: arbitration mode and the count of consecutive aux denials.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= PRI_CPU;
      wait_cnt <= 4'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Next state: count denials and enter the one-cycle forced aux slot when the limit is hit.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = 4'd0;
    case (state)
      PRI_CPU: begin
        if (aux_req && cpu_busy) begin
          if (wait_cnt + 4'd1 == MAX_WAIT_C) begin
            state_nxt = FORCE;
          end else begin
            wait_cnt_nxt = wait_cnt + 4'd1;
          end
        end
      end
      FORCE:   state_nxt = PRI_CPU;
      default: state_nxt = PRI_CPU;
    endcase
  end

  // Outputs: grant decision; the stall is a pure function of the FORCE state.
  always_comb begin
    cpu_stall = 1'b0;
    aux_gnt   = 1'b0;
    cpu_own   = 1'b0;
    case (state)
      PRI_CPU: begin
        cpu_own = cpu_busy;
        aux_gnt = ~cpu_busy & aux_req;
      end
      FORCE: begin
        // CPU inputs are frozen by the stall, so they are simply ignored here.
        cpu_stall = 1'b1;
        aux_gnt   = aux_req;
      end
      default: begin
        cpu_stall = 1'b0;
      end
    endcase
  end

  // Port mux: the owner drives the memory; an idle port still follows the CPU address/data.
  always_comb begin
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = cpu_addr;
    mem_wdata  = cpu_wdata;
    mem_funct3 = cpu_funct3;
    if (aux_gnt) begin
      mem_rd     = ~aux_we;
      mem_wr     = aux_we;
      mem_addr   = aux_addr;
      mem_wdata  = aux_wdata;
      mem_funct3 = aux_funct3;
    end else if (cpu_own) begin
      // Both enables are forwarded unchanged, even if both are high.
      mem_rd = cpu_rd;
      mem_wr = cpu_wr;
    end
  end

  // Aux response: capture read data one cycle after a granted read; writes give no response.
  always_ff @(posedge clk) begin
    if (reset) begin
      aux_rvalid <= 1'b0;
      aux_rdata  <= '0;
    end else begin
      aux_rvalid <= aux_gnt & ~aux_we;
      if (aux_gnt && !aux_we) begin
        aux_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small behavioural data memory.
// A second instance with MAX_WAIT=1 shares the stimulus and is checked only for its stall pattern.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_rd, cpu_wr;
  logic [8:0]  cpu_addr;
  logic [31:0] cpu_wdata;
  logic [2:0]  cpu_funct3;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        aux_req, aux_we;
  logic [8:0]  aux_addr;
  logic [31:0] aux_wdata;
  logic [2:0]  aux_funct3;
  logic        aux_gnt, aux_rvalid;
  logic [31:0] aux_rdata;
  logic        mem_rd, mem_wr;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_rdata;

  logic        cpu_stall1, aux_gnt1, aux_rvalid1, mem_rd1, mem_wr1;
  logic [31:0] cpu_rdata1, aux_rdata1, mem_wdata1;
  logic [8:0]  mem_addr1;
  logic [2:0]  mem_funct3_1;

  logic [31:0] tbmem [0:127];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  assign mem_rdata = mem_rd ? tbmem[mem_addr[8:2]] : 32'h0;

  dmem_arbiter #(.DATA_W(32), .DM_ADDRESS(9), .MAX_WAIT(4)) u_dut (
    .clk(clk), .reset(reset),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_funct3(cpu_funct3), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
    .aux_funct3(aux_funct3), .aux_gnt(aux_gnt), .aux_rvalid(aux_rvalid), .aux_rdata(aux_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_funct3(mem_funct3), .mem_rdata(mem_rdata)
  );

  dmem_arbiter #(.DATA_W(32), .DM_ADDRESS(9), .MAX_WAIT(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_funct3(cpu_funct3), .cpu_rdata(cpu_rdata1), .cpu_stall(cpu_stall1),
    .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
    .aux_funct3(aux_funct3), .aux_gnt(aux_gnt1), .aux_rvalid(aux_rvalid1), .aux_rdata(aux_rdata1),
    .mem_rd(mem_rd1), .mem_wr(mem_wr1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_funct3(mem_funct3_1), .mem_rdata(mem_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_rd = 0; cpu_wr = 0; cpu_addr = 9'h0; cpu_wdata = 32'h0; cpu_funct3 = 3'd2;
    aux_req = 0; aux_we = 0; aux_addr = 9'h0; aux_wdata = 32'h0; aux_funct3 = 3'd2;
  endtask

  // Two reset edges with idle inputs; the caller's next input set is cycle 0.
  task automatic do_reset();
    idle_inputs();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1; cpu_rd = 1; cpu_addr = 9'h044; aux_req = 1; aux_addr = 9'h010;
    tick();
    tick();
    reset = 0;
    total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", cpu_stall); end
    total++; if (aux_rvalid !== 1'b0) begin bad++; $display("FAIL reset_rvalid: got %b want 0", aux_rvalid); end
    total++; if (aux_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata: got %h want 0", aux_rdata); end
    total++; if (u_dut.wait_cnt !== 4'd0) begin bad++; $display("FAIL reset_wait_cnt: got %0d want 0", u_dut.wait_cnt); end
    #2;
    total++; if (aux_gnt !== 1'b0) begin bad++; $display("FAIL reset_release_gnt: got %b want 0", aux_gnt); end
    total++; if (mem_rd !== 1'b1 || mem_addr !== 9'h044) begin bad++; $display("FAIL reset_release_cpu: got rd=%b addr=%h want rd=1 addr=044", mem_rd, mem_addr); end
  endtask

  // Grant is combinational, so it still happens while reset is held.
  task automatic test_reset_grant();
    idle_inputs();
    reset = 1; aux_req = 1; aux_addr = 9'h010;
    #2;
    total++; if (aux_gnt !== 1'b1 || mem_rd !== 1'b1) begin bad++; $display("FAIL reset_grant: got gnt=%b rd=%b want 1 1", aux_gnt, mem_rd); end
    tick();
    total++; if (aux_rvalid !== 1'b0) begin bad++; $display("FAIL reset_grant_rvalid: got %b want 0", aux_rvalid); end
    reset = 0;
  endtask

  task automatic test_aux_read();
    do_reset();
    aux_req = 1; aux_we = 0; aux_addr = 9'h010;
    #2;
    total++; if (aux_gnt !== 1'b1) begin bad++; $display("FAIL aux_read_gnt: got %b want 1", aux_gnt); end
    total++; if (mem_rd !== 1'b1 || mem_wr !== 1'b0 || mem_addr !== 9'h010) begin bad++; $display("FAIL aux_read_port: got rd=%b wr=%b addr=%h want 1 0 010", mem_rd, mem_wr, mem_addr); end
    tick();
    aux_req = 0;
    total++; if (aux_rvalid !== 1'b1 || aux_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL aux_read_data: got v=%b d=%h want 1 deadbeef", aux_rvalid, aux_rdata); end
    tick();
    total++; if (aux_rvalid !== 1'b0 || aux_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL aux_read_hold: got v=%b d=%h want 0 deadbeef", aux_rvalid, aux_rdata); end
  endtask

  task automatic test_force();
    logic exp_stall;
    do_reset();
    cpu_wr = 1; cpu_addr = 9'h020; cpu_wdata = 32'h11;
    aux_req = 1; aux_we = 1; aux_addr = 9'h030; aux_wdata = 32'h55;
    for (int c = 0; c < 10; c++) begin
      exp_stall = (c == 4) || (c == 9);
      #2;
      total++; if (cpu_stall !== exp_stall || aux_gnt !== exp_stall) begin bad++; $display("FAIL force_c%0d: got stall=%b gnt=%b want %b", c, cpu_stall, aux_gnt, exp_stall); end
      total++; if (mem_wr !== 1'b1 || mem_rd !== 1'b0 || mem_addr !== (exp_stall ? 9'h030 : 9'h020) || mem_wdata !== (exp_stall ? 32'h55 : 32'h11)) begin
        bad++; $display("FAIL force_port_c%0d: got wr=%b rd=%b addr=%h wdata=%h", c, mem_wr, mem_rd, mem_addr, mem_wdata);
      end
      total++; if (cpu_stall1 !== c[0]) begin bad++; $display("FAIL force_max1_c%0d: got %b want %b", c, cpu_stall1, c[0]); end
      total++; if (aux_rvalid !== 1'b0) begin bad++; $display("FAIL force_no_rvalid_c%0d: got %b want 0", c, aux_rvalid); end
      tick();
    end
  endtask

  task automatic test_release();
    do_reset();
    aux_req = 1; aux_we = 0; aux_addr = 9'h004;
    cpu_rd = 1; cpu_addr = 9'h040;
    for (int c = 0; c < 3; c++) begin
      #2;
      total++; if (aux_gnt !== 1'b0 || cpu_stall !== 1'b0) begin bad++; $display("FAIL release_deny_c%0d: got gnt=%b stall=%b want 0 0", c, aux_gnt, cpu_stall); end
      tick();
    end
    cpu_rd = 0;
    #2;
    total++; if (aux_gnt !== 1'b1 || cpu_stall !== 1'b0 || mem_rd !== 1'b1 || mem_addr !== 9'h004) begin
      bad++; $display("FAIL release_grant: got gnt=%b stall=%b rd=%b addr=%h want 1 0 1 004", aux_gnt, cpu_stall, mem_rd, mem_addr);
    end
    tick();
    total++; if (u_dut.wait_cnt !== 4'd0) begin bad++; $display("FAIL release_wait_cnt: got %0d want 0", u_dut.wait_cnt); end
    total++; if (aux_rvalid !== 1'b1 || aux_rdata !== 32'hA) begin bad++; $display("FAIL release_data: got v=%b d=%h want 1 0000000a", aux_rvalid, aux_rdata); end
    aux_addr = 9'h008; cpu_rd = 1;
    for (int c = 0; c < 5; c++) begin
      #2;
      total++; if (cpu_stall !== (c == 4) || aux_gnt !== (c == 4)) begin bad++; $display("FAIL release_second_c%0d: got stall=%b gnt=%b want %b", c, cpu_stall, aux_gnt, (c == 4)); end
      tick();
    end
    total++; if (aux_rvalid !== 1'b1 || aux_rdata !== 32'hB) begin bad++; $display("FAIL release_second_data: got v=%b d=%h want 1 0000000b", aux_rvalid, aux_rdata); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    aux_req = 1; aux_we = 0; aux_addr = 9'h004;
    #2;
    total++; if (aux_gnt !== 1'b1) begin bad++; $display("FAIL b2b_gnt0: got %b want 1", aux_gnt); end
    tick();
    aux_addr = 9'h008;
    total++; if (aux_rvalid !== 1'b1 || aux_rdata !== 32'hA) begin bad++; $display("FAIL b2b_data0: got v=%b d=%h want 1 0000000a", aux_rvalid, aux_rdata); end
    tick();
    aux_we = 1; aux_addr = 9'h00C; aux_wdata = 32'h77;
    total++; if (aux_rvalid !== 1'b1 || aux_rdata !== 32'hB) begin bad++; $display("FAIL b2b_data1: got v=%b d=%h want 1 0000000b", aux_rvalid, aux_rdata); end
    #2;
    total++; if (aux_gnt !== 1'b1 || mem_wr !== 1'b1 || mem_rd !== 1'b0 || mem_wdata !== 32'h77) begin bad++; $display("FAIL b2b_write: got gnt=%b wr=%b rd=%b wd=%h", aux_gnt, mem_wr, mem_rd, mem_wdata); end
    tick();
    aux_we = 0; aux_addr = 9'h004;
    total++; if (aux_rvalid !== 1'b0 || aux_rdata !== 32'hB) begin bad++; $display("FAIL b2b_write_norsp: got v=%b d=%h want 0 0000000b", aux_rvalid, aux_rdata); end
    tick();
    aux_req = 0;
    total++; if (aux_rvalid !== 1'b1 || aux_rdata !== 32'hA) begin bad++; $display("FAIL b2b_data2: got v=%b d=%h want 1 0000000a", aux_rvalid, aux_rdata); end
    cpu_rd = 1; cpu_wr = 1; cpu_addr = 9'h050;
    #2;
    total++; if (mem_rd !== 1'b1 || mem_wr !== 1'b1 || mem_addr !== 9'h050) begin bad++; $display("FAIL both_enables: got rd=%b wr=%b addr=%h want 1 1 050", mem_rd, mem_wr, mem_addr); end
    tick();
  endtask

  task automatic test_force_idle();
    do_reset();
    cpu_rd = 1; cpu_addr = 9'h060; aux_req = 1; aux_we = 0; aux_addr = 9'h004;
    repeat (4) tick();
    aux_req = 0;
    #2;
    total++; if (cpu_stall !== 1'b1 || aux_gnt !== 1'b0 || mem_rd !== 1'b0 || mem_wr !== 1'b0) begin
      bad++; $display("FAIL force_idle: got stall=%b gnt=%b rd=%b wr=%b want 1 0 0 0", cpu_stall, aux_gnt, mem_rd, mem_wr);
    end
    tick();
    #2;
    total++; if (cpu_stall !== 1'b0 || mem_rd !== 1'b1 || mem_addr !== 9'h060) begin bad++; $display("FAIL force_idle_after: got stall=%b rd=%b addr=%h want 0 1 060", cpu_stall, mem_rd, mem_addr); end
    tick();
  endtask

  task automatic test_reset_in_force();
    do_reset();
    cpu_wr = 1; cpu_addr = 9'h020; aux_req = 1; aux_we = 0; aux_addr = 9'h008;
    repeat (4) tick();
    #2;
    total++; if (cpu_stall !== 1'b1 || aux_gnt !== 1'b1) begin bad++; $display("FAIL rif_force: got stall=%b gnt=%b want 1 1", cpu_stall, aux_gnt); end
    reset = 1;
    tick();
    total++; if (cpu_stall !== 1'b0 || aux_rvalid !== 1'b0) begin bad++; $display("FAIL rif_after: got stall=%b rvalid=%b want 0 0", cpu_stall, aux_rvalid); end
    total++; if (u_dut.state !== 1'b0 || u_dut.wait_cnt !== 4'd0) begin bad++; $display("FAIL rif_state: got fsm=%b wait=%0d want 0 0", u_dut.state, u_dut.wait_cnt); end
    reset = 0;
    idle_inputs();
    tick();
  endtask

  initial begin
    for (int i = 0; i < 128; i++) tbmem[i] = 32'h1000_0000 + i;
    tbmem[1] = 32'hA;
    tbmem[2] = 32'hB;
    tbmem[4] = 32'hDEADBEEF;
    idle_inputs();
    reset = 1;
    #1;
    test_reset();
    test_reset_grant();
    test_aux_read();
    test_force();
    test_release();
    test_back_to_back();
    test_force_idle();
    test_reset_in_force();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-requester arbiter for the single data-memory port. Requester 0 is the pipeline MEM stage (EX/MEM register outputs). Requester 1 is an auxiliary port used for testbench loading, debug and future DMA. The pipeline has fixed priority. A starvation counter forces a one-cycle pipeline stall, so the auxiliary requester is served within a bounded number of cycles.

Parameters:
DATA_W, 32, data width of the memory and both requesters
DM_ADDRESS, 9, data-memory byte address width
MAX_WAIT, 4, number of consecutive denied aux cycles before a forced stall; legal range 1..15

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
cpu_rd  input  1  MEM-stage read enable
cpu_wr  input  1  MEM-stage write enable
cpu_addr  input  DM_ADDRESS  MEM-stage byte address
cpu_wdata  input  DATA_W  MEM-stage store data
cpu_funct3  input  3  MEM-stage access size/sign
cpu_rdata  output  DATA_W  load data to the MEM/WB register
cpu_stall  output  1  freeze PC, IF/ID, ID/EX and EX/MEM for one cycle
aux_req  input  1  auxiliary access request
aux_we  input  1  1 = write, 0 = read
aux_addr  input  DM_ADDRESS  auxiliary byte address
aux_wdata  input  DATA_W  auxiliary write data
aux_funct3  input  3  auxiliary access size/sign
aux_gnt  output  1  auxiliary access performed this cycle
aux_rvalid  output  1  auxiliary read data valid
aux_rdata  output  DATA_W  auxiliary read data
mem_rd  output  1  to datamemory read enable
mem_wr  output  1  to datamemory write enable
mem_addr  output  DM_ADDRESS  to datamemory address
mem_wdata  output  DATA_W  to datamemory write data
mem_funct3  output  3  to datamemory funct3
mem_rdata  input  DATA_W  from datamemory; valid in the same cycle as mem_rd

Behaviour:
- Clock and reset are fixed: one clock clk; reset is synchronous and active-high.
- Registered state: fsm in {PRI_CPU, FORCE}; wait_cnt (4 bits); aux_rvalid; aux_rdata.
- Reset values: fsm=PRI_CPU, wait_cnt=0, aux_rvalid=0, aux_rdata=0. Consequently cpu_stall=0 in the cycle after the reset edge.
- cpu_busy = cpu_rd | cpu_wr.
- Combinational grant in PRI_CPU:
  - If cpu_busy: CPU owns the port and aux_gnt=0.
  - Else if aux_req: aux_gnt=1 and aux owns the port.
  - Else: no owner.
- Combinational grant in FORCE:
  - cpu_stall=1 (Moore output).
  - aux_gnt=aux_req and aux owns the port. CPU inputs are ignored; the pipeline holds them.
- Port mux:
  - Owner's rd/wr/addr/wdata/funct3 drive mem_*.
  - Aux read drives mem_rd=1 and mem_wr=0. Aux write drives mem_wr=1 and mem_rd=0.
  - With no owner, mem_rd=mem_wr=0 and addr/wdata/funct3 follow the cpu_* inputs.
- cpu_rdata = mem_rdata (pass-through); meaningful only when the CPU owns the port.
- wait_cnt update, in PRI_CPU only:
  - aux_req & cpu_busy: wait_cnt+1.
  - Otherwise: wait_cnt=0.
  - When a denial brings wait_cnt+1 to MAX_WAIT: next fsm=FORCE and wait_cnt<=0.
- FORCE always returns to PRI_CPU after exactly one cycle, with wait_cnt=0.
- Aux response:
  - aux_rvalid <= aux_gnt & ~aux_we.
  - aux_rdata <= mem_rdata when aux_gnt & ~aux_we; otherwise aux_rdata holds.
  - Read latency is 1 cycle after the grant; writes produce no response.
- Aux handshake rules:
  - The aux requester holds req/we/addr/wdata/funct3 stable until it samples aux_gnt=1.
  - One access is performed per granted cycle; back-to-back grants are allowed.
- Boundary conditions:
  - aux_req low during FORCE (protocol violation): port idle, stall still asserted for that cycle.
  - cpu_rd & cpu_wr both high: forwarded unchanged.
  - MAX_WAIT=1: force after a single denial.
  - Reset during FORCE: returns to PRI_CPU; aux_rvalid cleared at the reset edge.
  - Reset asserted while aux_req=1 and CPU idle: the combinational grant still occurs. Reset only clears registered state.

Test Plan:
- Reset with cpu_rd=1, aux_req=1 for 2 cycles, then release -> cpu_stall=0, aux_rvalid=0, aux_rdata=0x0; the cycle after release grants the CPU, aux_gnt=0.
- CPU idle, aux read addr 0x010, mem holds 0xDEADBEEF -> same cycle aux_gnt=1, mem_rd=1, mem_addr=0x010; next cycle aux_rvalid=1, aux_rdata=0xDEADBEEF.
- MAX_WAIT=4, cpu_wr addr 0x020 data 0x11 every cycle, aux write addr 0x030 data 0x55 -> cycles 0-3: mem_wr to 0x020, aux_gnt=0; cycle 4: cpu_stall=1, aux_gnt=1, mem_addr=0x030, mem_wdata=0x55; cycle 5: cpu_stall=0, CPU served again; next force occurs at cycle 9.
- aux_req held, CPU busy 3 cycles then idle (MAX_WAIT=4) -> grant at cycle 3 with no stall, wait_cnt=0; a second request later needs a full 4 denials before a force.
- Back-to-back aux reads 0x004 then 0x008 with CPU idle (mem 0xA, 0xB) -> aux_rvalid high for 2 consecutive cycles with aux_rdata 0xA then 0xB; an aux write in between gives no aux_rvalid.
- Reset asserted during a FORCE cycle -> next cycle cpu_stall=0, aux_rvalid=0, fsm=PRI_CPU, wait_cnt=0.
